// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand/result bundle between a requester and the sequential multiplier
interface seq_multiplier_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               sign_mode;
    logic               abort;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] z;

    modport master (output start, sign_mode, abort, a, b, input busy, done, z);
    modport slave  (input start, sign_mode, abort, a, b, output busy, done, z);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, one multiplier bit per cycle, signed or unsigned
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic clk,
    input logic reset,
    seq_multiplier_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH:0]     acc, ext_a, sum, acc_nx;
    logic [WIDTH-1:0]   a_r, q, q_nx;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] z_r;
    logic               sgn, last, load;

    assign last  = cnt == CNT_W'(WIDTH - 1);
    assign load  = state != RUN && bus.start;
    assign ext_a = {sgn & a_r[WIDTH-1], a_r};
    // the multiplier's sign bit carries weight -2^(WIDTH-1), hence subtract on the final step
    assign sum    = !q[0] ? acc : (sgn && last) ? acc - ext_a : acc + ext_a;
    assign acc_nx = {sgn & sum[WIDTH], sum[WIDTH:1]};
    assign q_nx   = {sum[0], q[WIDTH-1:1]};

    assign bus.busy = state == RUN;
    assign bus.done = state == DONE;
    assign bus.z    = z_r;

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     state_nx = bus.abort ? IDLE : last ? DONE : RUN;
            default: state_nx = bus.start ? RUN : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            q     <= '0;
            a_r   <= '0;
            sgn   <= 1'b0;
            cnt   <= '0;
            z_r   <= '0;
        end else begin
            state <= state_nx;
            if (load) begin
                a_r <= bus.a;
                q   <= bus.b;
                sgn <= bus.sign_mode;
                acc <= '0;
                cnt <= '0;
            end else if (state == RUN) begin
                acc <= acc_nx;
                q   <= q_nx;
                cnt <= cnt + CNT_W'(1);
                if (last && !bus.abort) z_r <= {acc_nx[WIDTH-1:0], q_nx};
            end
        end
    end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scenario tasks with a queue scoreboard fed by an independent product model
module tb_seq_multiplier;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_multiplier_if #(.WIDTH(W)) bus();
    seq_multiplier #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_z;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
        longint sx, sy;
        if (!sm) return {32'b0, x} * {32'b0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm, input bit push);
        @(negedge clk);
        bus.start = 1'b1; bus.a = x; bus.b = y; bus.sign_mode = sm;
        if (push) exp_q.push_back(ref_mul(x, y, sm));
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.sign_mode = 1'($urandom_range(1, 0));
    endtask

    task automatic wait_done(output int cycles, output int busy_n);
        cycles = 0; busy_n = 0;
        do begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            cycles++;
        end while (!bus.done && cycles < 100);
    endtask

    task automatic count_done(input int n, output int seen);
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.sign_mode = 1'b0; bus.a = '0; bus.b = '0;
        @(negedge clk);
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else pass_cnt++;
        total_cnt++; if (bus.z !== '0) $display("FAIL reset_z: got %h expected 0", bus.z); else pass_cnt++;
        reset = 1'b0;
        last_z = '0;
    endtask

    task automatic test_unsigned();
        int c, bn;
        logic [2*W-1:0] e;
        drive_start(3, 5, 1'b0, 1'b1);
        wait_done(c, bn);
        e = exp_q.pop_front();
        total_cnt++; if (c !== 32) $display("FAIL unsigned_latency: got %0d expected 32", c); else pass_cnt++;
        total_cnt++; if (bn !== 32) $display("FAIL unsigned_busy_cycles: got %0d expected 32", bn); else pass_cnt++;
        total_cnt++; if (bus.z !== e) $display("FAIL unsigned_z: got %h expected %h", bus.z, e); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL unsigned_busy_at_done: got %b expected 0", bus.busy); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.done !== 1'b0) $display("FAIL done_one_cycle: got %b expected 0", bus.done); else pass_cnt++;
        last_z = e;
    endtask

    task automatic test_signed();
        logic [W-1:0] xs[6] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'h00000000};
        logic [W-1:0] ys[6] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000007, 32'h7FFFFFFF, 32'h80000000};
        logic sms[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int c, bn;
        logic [2*W-1:0] e;
        for (int i = 0; i < 6; i++) begin
            drive_start(xs[i], ys[i], sms[i], 1'b1);
            @(negedge clk);
            total_cnt++; if (bus.z !== last_z) $display("FAIL z_hold_in_run_%0d: got %h expected %h", i, bus.z, last_z); else pass_cnt++;
            wait_done(c, bn);
            e = exp_q.pop_front();
            total_cnt++; if (c + 1 !== 32) $display("FAIL signed_latency_%0d: got %0d expected 32", i, c + 1); else pass_cnt++;
            total_cnt++; if (bus.z !== e) $display("FAIL signed_z_%0d: got %h expected %h", i, bus.z, e); else pass_cnt++;
            last_z = e;
        end
    endtask

    task automatic test_abort();
        int c, bn, seen;
        logic [2*W-1:0] e;
        drive_start(9, 9, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.busy); else pass_cnt++;
        total_cnt++; if (bus.z !== last_z) $display("FAIL abort_z: got %h expected %h", bus.z, last_z); else pass_cnt++;
        count_done(40, seen);
        total_cnt++; if (seen !== 0) $display("FAIL abort_no_done: got %0d expected 0", seen); else pass_cnt++;
        // start and abort together while idle: start must win
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1; bus.a = 32'h12345678; bus.b = 32'h9ABCDEF0; bus.sign_mode = 1'b1;
        exp_q.push_back(ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b1));
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        wait_done(c, bn);
        e = exp_q.pop_front();
        total_cnt++; if (c !== 32) $display("FAIL start_beats_abort_latency: got %0d expected 32", c); else pass_cnt++;
        total_cnt++; if (bus.z !== e) $display("FAIL start_beats_abort_z: got %h expected %h", bus.z, e); else pass_cnt++;
        last_z = e;
    endtask

    task automatic test_ignored_start();
        int c, bn, seen;
        logic [2*W-1:0] e;
        drive_start(32'hDEADBEEF, 32'h00C0FFEE, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.a = 32'h1; bus.b = 32'h1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(c, bn);
        e = exp_q.pop_front();
        total_cnt++; if (c + 5 !== 32) $display("FAIL ignored_start_latency: got %0d expected 32", c + 5); else pass_cnt++;
        total_cnt++; if (bus.z !== e) $display("FAIL ignored_start_z: got %h expected %h", bus.z, e); else pass_cnt++;
        count_done(40, seen);
        total_cnt++; if (seen !== 0) $display("FAIL ignored_start_queued: got %0d expected 0", seen); else pass_cnt++;
        last_z = e;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        drive_start(32'h0BADF00D, 32'h87654321, 1'b1, 1'b0);
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (bus.z !== '0) $display("FAIL midrun_reset_z: got %h expected 0", bus.z); else pass_cnt++;
        total_cnt++; if (bus.busy !== 1'b0) $display("FAIL midrun_reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        last_z = '0;
        count_done(50, seen);
        total_cnt++; if (seen !== 0) $display("FAIL midrun_reset_no_done: got %0d expected 0", seen); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int c, bn;
        logic [2*W-1:0] e;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'hFFFFFFF9; bus.b = 32'h00000013; bus.sign_mode = 1'b1;
        exp_q.push_back(ref_mul(32'hFFFFFFF9, 32'h00000013, 1'b1));
        @(negedge clk);
        bus.a = 32'hCAFEF00D; bus.b = 32'h76543210; bus.sign_mode = 1'b0;
        exp_q.push_back(ref_mul(32'hCAFEF00D, 32'h76543210, 1'b0));
        wait_done(c, bn);
        e = exp_q.pop_front();
        total_cnt++; if (bus.z !== e) $display("FAIL b2b_first_z: got %h expected %h", bus.z, e); else pass_cnt++;
        @(negedge clk);
        bus.start = 1'b0;
        total_cnt++; if (bus.busy !== 1'b1) $display("FAIL b2b_no_bubble: got %b expected 1", bus.busy); else pass_cnt++;
        wait_done(c, bn);
        e = exp_q.pop_front();
        total_cnt++; if (c + 1 !== 33) $display("FAIL b2b_spacing: got %0d expected 33", c + 1); else pass_cnt++;
        total_cnt++; if (bus.z !== e) $display("FAIL b2b_second_z: got %h expected %h", bus.z, e); else pass_cnt++;
        last_z = e;
    endtask

    task automatic test_random();
        int c, bn;
        logic [W-1:0] x, y;
        logic sm;
        logic [2*W-1:0] e;
        for (int i = 0; i < 12; i++) begin
            x = (i == 0) ? '0 : W'($urandom);
            y = W'($urandom);
            sm = 1'($urandom_range(1, 0));
            drive_start(x, y, sm, 1'b1);
            wait_done(c, bn);
            e = exp_q.pop_front();
            total_cnt++; if (bus.z !== e) $display("FAIL random_z_%0d: got %h expected %h (a=%h b=%h s=%b)", i, bus.z, e, x, y, sm); else pass_cnt++;
            last_z = e;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_abort();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
